// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared timebase.
// - Programmable period P.
// - Edge-aligned counting: 0..P.
// - Center-aligned counting: 0..P..1.
// - Double-buffered period, duty and mode. They change only at a cycle
//   boundary, or at once while the timebase is disabled.
// Optional feature: define PWM_DEADTIME_EN to get complementary outputs
// (pwm_out_n) with a DEADTIME-cycle dead band on every channel.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEADTIME = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      mode,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic [CHANNELS-1:0]       pwm_out_n,
`endif
  output logic                      cycle_start,
  output logic                      load_ack
);

  // A dead band outside 1..255 cannot be represented by the 8-bit run counters.
  if (DEADTIME < 1 || DEADTIME > 255) begin : g_deadtime_range_invalid
    $error("pwm_multi: DEADTIME must be in 1..255");
  end

  // Timebase state.
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_q, dir_d;          // 0 = counting up, 1 = down

  // Active and shadow configuration.
  logic [WIDTH-1:0]          per_q, per_d;
  logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
  logic                      mode_q, mode_d;
  logic [WIDTH-1:0]          per_sh_q;
  logic [CHANNELS*WIDTH-1:0] duty_sh_q;
  logic                      mode_sh_q;
  logic                      pend_q;

  logic                      cycle_start_q, load_ack_q;
  logic                      boundary, apply;
  logic [CHANNELS-1:0]       raw;

  assign boundary = en && (cnt_q == '0);
  // While disabled every cycle is an update point, so pending values land at once.
  assign apply    = (boundary || !en) && (load || pend_q);

  // Effective configuration for this cycle: the value that is active from now on.
  // Using it for compare and counting makes the first output of a new period
  // (the one coinciding with load_ack) already reflect the new settings.
  always_comb begin
    per_d  = per_q;
    duty_d = duty_q;
    mode_d = mode_q;
    if (apply) begin
      per_d  = load ? period : per_sh_q;
      duty_d = load ? duty   : duty_sh_q;
      mode_d = load ? mode   : mode_sh_q;
    end
  end

  // Next counter value and direction for edge and center alignment.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode_d) begin
      dir_d = 1'b0;
      cnt_d = (cnt_q == per_d) ? '0 : cnt_q + WIDTH'(1);
    end else if (!dir_q) begin
      if (cnt_q == per_d) begin
        // P of 0 or 1 has no down-slope: go straight back to 0.
        if (per_d <= WIDTH'(1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = per_d - WIDTH'(1);
          dir_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
      if (cnt_q == WIDTH'(1)) dir_d = 1'b0;
    end
  end

  // Per-channel raw compare against the effective duty.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_raw
    assign raw[gi] = cnt_q < duty_d[gi*WIDTH +: WIDTH];
  end

  // Timebase, configuration registers and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      per_q         <= '1;
      duty_q        <= '0;
      mode_q        <= 1'b0;
      per_sh_q      <= '1;
      duty_sh_q     <= '0;
      mode_sh_q     <= 1'b0;
      pend_q        <= 1'b0;
      cycle_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      mode_q <= mode_d;
      if (load) begin
        per_sh_q  <= period;
        duty_sh_q <= duty;
        mode_sh_q <= mode;
      end
      pend_q        <= apply ? 1'b0 : (pend_q | load);
      cycle_start_q <= boundary;
      load_ack_q    <= apply;
    end
  end

  assign cycle_start = cycle_start_q;
  assign load_ack    = load_ack_q;

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DT = 8'(DEADTIME);

  logic [CHANNELS-1:0] pwm_p, pwm_n;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_dt
    logic [7:0] hi_q, lo_q;   // prior consecutive high / low raw cycles, saturating at DT
    logic       p_q, n_q;

    // Each output rises only after raw has held its level for DT cycles, falls right after the raw edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hi_q <= '0;
        lo_q <= '0;
        p_q  <= 1'b0;
        n_q  <= 1'b0;
      end else if (!en) begin
        hi_q <= '0;
        lo_q <= '0;
        p_q  <= 1'b0;
        n_q  <= 1'b0;
      end else begin
        p_q  <= raw[gi] && (hi_q == DT);
        n_q  <= !raw[gi] && (lo_q == DT);
        hi_q <= raw[gi]  ? ((hi_q == DT) ? hi_q : hi_q + 8'd1) : 8'd0;
        lo_q <= !raw[gi] ? ((lo_q == DT) ? lo_q : lo_q + 8'd1) : 8'd0;
      end
    end

    assign pwm_p[gi] = p_q;
    assign pwm_n[gi] = n_q;
  end

  assign pwm_out   = pwm_p;
  assign pwm_out_n = pwm_n;
`else
  logic [CHANNELS-1:0] pwm_q;

  // Registered raw compare, forced low while the timebase is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_q <= '0;
    else      pwm_q <= en ? raw : '0;
  end

  assign pwm_out = pwm_q;
`endif

endmodule
